reg_access_ctrl: RTL and testbench

REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

---
 rtl/rac_pkg.sv | 30 +++
 rtl/reg_access_ctrl_if.sv | 36 +++
 rtl/crc16to8_parallel.sv | 31 +++
 rtl/reg_access_ctrl.sv | 106 ++++++++++
 tb/tb_reg_access_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rac_pkg.sv
//------------------------------------------------------------------------------
// Module   : rac_pkg
// Brief    : Shared widths, CRC polynomial and FSM state type for the
//            register access controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rac_pkg;

   localparam int REG_AW    = 7;
   localparam int REG_DW    = 8;
   localparam int REG_CRC_W = 8;

   // CRC-8 x^8+x^2+x+1, zero init, MSB first, no reflection
   localparam logic [REG_CRC_W-1:0] C_CRC_POLY = 8'h07;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WCHK  = 3'd1,
      WR    = 3'd2,
      RD    = 3'd3,
      RWAIT = 3'd4,
      ACK   = 3'd5,
      GAP   = 3'd6
   } rac_state_e;

endpackage

`default_nettype wire

// File: rtl/reg_access_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : reg_access_ctrl_if
// Brief    : SPI-side request/acknowledge bundle of the register access
//            controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface reg_access_ctrl_if;
   import rac_pkg::*;

   logic                 spi_rac_wr_req;
   logic                 spi_rac_rd_req;
   logic [REG_AW-1:0]    spi_rac_addr;
   logic [REG_DW-1:0]    spi_rac_wdata;
   logic [REG_CRC_W-1:0] spi_rac_wcrc;
   logic                 rac_spi_wack;
   logic                 rac_spi_rack;
   logic [REG_DW-1:0]    rac_spi_data;
   logic [REG_AW-1:0]    rac_spi_addr;

   modport master (
      output spi_rac_wr_req, spi_rac_rd_req, spi_rac_addr, spi_rac_wdata,
             spi_rac_wcrc,
      input  rac_spi_wack, rac_spi_rack, rac_spi_data, rac_spi_addr
   );

   modport slave (
      input  spi_rac_wr_req, spi_rac_rd_req, spi_rac_addr, spi_rac_wdata,
             spi_rac_wcrc,
      output rac_spi_wack, rac_spi_rack, rac_spi_data, rac_spi_addr
   );

endinterface

`default_nettype wire

// File: rtl/crc16to8_parallel.sv
//------------------------------------------------------------------------------
// Module   : crc16to8_parallel
// Brief    : Combinational CRC-8 over a 16-bit word, unrolled bit-serial LFSR.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module crc16to8_parallel
   import rac_pkg::*;
(
   input  wire logic [15:0]          i_data,
   output logic      [REG_CRC_W-1:0] o_crc
);

   logic [REG_CRC_W-1:0] w_acc;
   logic                 w_fb;

   always_comb begin
      w_acc = '0;
      w_fb  = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         w_fb  = w_acc[REG_CRC_W-1] ^ i_data[i];
         w_acc = {w_acc[REG_CRC_W-2:0], 1'b0} ^ (w_fb ? C_CRC_POLY : '0);
      end
   end

   assign o_crc = w_acc;

endmodule

`default_nettype wire

// File: rtl/reg_access_ctrl.sv
//------------------------------------------------------------------------------
// Module   : reg_access_ctrl
// Brief    : Serialises SPI read/write requests onto the register bank,
//            rejecting writes whose frame CRC does not match.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg_access_ctrl
   import rac_pkg::*;
(
   input  wire logic              i_clk,
   input  wire logic              i_rst_n,
   reg_access_ctrl_if.slave       spi,
   output logic                   o_reg_wr_en,
   output logic                   o_reg_rd_en,
   output logic [REG_AW-1:0]      o_reg_addr,
   output logic [REG_DW-1:0]      o_reg_wdata,
   input  wire logic [REG_DW-1:0] i_reg_rdata,
   output logic                   o_rac_crc_err
);

   rac_state_e           r_state;
   rac_state_e           w_next;
   logic [REG_AW-1:0]    r_addr;
   logic [REG_DW-1:0]    r_wdata;
   logic [REG_CRC_W-1:0] r_wcrc;
   logic                 r_is_wr;
   logic [REG_DW-1:0]    r_resp_data;
   logic [REG_AW-1:0]    r_resp_addr;
   logic                 r_crc_err;
   logic [REG_CRC_W-1:0] w_crc;
   logic                 w_crc_ok;

   crc16to8_parallel u_crc (
      .i_data ({1'b1, r_addr, r_wdata}),
      .o_crc  (w_crc)
   );

   assign w_crc_ok = (w_crc == r_wcrc);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   // Only IDLE looks at the requests; write wins a simultaneous request.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (spi.spi_rac_wr_req)      w_next = WCHK;
            else if (spi.spi_rac_rd_req) w_next = RD;
         end
         WCHK:    w_next = w_crc_ok ? WR : ACK;
         WR:      w_next = ACK;
         RD:      w_next = RWAIT;
         RWAIT:   w_next = ACK;
         ACK:     w_next = GAP;
         GAP:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wcrc      <= '0;
         r_is_wr     <= 1'b0;
         r_resp_data <= '0;
         r_resp_addr <= '0;
         r_crc_err   <= 1'b0;
      end else begin
         if (r_state == IDLE && spi.spi_rac_wr_req) begin
            r_addr  <= spi.spi_rac_addr;
            r_wdata <= spi.spi_rac_wdata;
            r_wcrc  <= spi.spi_rac_wcrc;
            r_is_wr <= 1'b1;
         end else if (r_state == IDLE && spi.spi_rac_rd_req) begin
            r_addr  <= spi.spi_rac_addr;
            r_is_wr <= 1'b0;
         end
         r_crc_err <= (r_state == WCHK) && !w_crc_ok;
         // Response registers change only on entry to ACK, so they hold
         // steady between acknowledges; RWAIT->ACK is the rdata capture edge.
         if (w_next == ACK) begin
            r_resp_data <= r_is_wr ? r_wdata : i_reg_rdata;
            r_resp_addr <= r_addr;
         end
      end
   end

   assign o_reg_wr_en      = (r_state == WR);
   assign o_reg_rd_en      = (r_state == RD);
   assign o_reg_addr       = r_addr;
   assign o_reg_wdata      = r_wdata;
   assign o_rac_crc_err    = r_crc_err;
   assign spi.rac_spi_wack = (r_state == ACK) &&  r_is_wr;
   assign spi.rac_spi_rack = (r_state == ACK) && !r_is_wr;
   assign spi.rac_spi_data = r_resp_data;
   assign spi.rac_spi_addr = r_resp_addr;

endmodule

`default_nettype wire

// File: tb/tb_reg_access_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_reg_access_ctrl
// Brief    : Scoreboard bench for reg_access_ctrl with a register-bank model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_reg_access_ctrl;
   import rac_pkg::*;

   typedef struct {
      bit        is_wr;
      logic [7:0] data;
      logic [6:0] addr;
      bit        err;
      int        cyc;
   } ack_exp_t;

   typedef struct {
      logic [6:0] addr;
      logic [7:0] data;
      int        cyc;
   } bank_exp_t;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       o_reg_wr_en, o_reg_rd_en, o_rac_crc_err;
   logic [6:0] o_reg_addr;
   logic [7:0] o_reg_wdata;
   logic [7:0] i_reg_rdata = 8'h00;

   reg_access_ctrl_if spi ();

   reg_access_ctrl dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .spi           (spi.slave),
      .o_reg_wr_en   (o_reg_wr_en),
      .o_reg_rd_en   (o_reg_rd_en),
      .o_reg_addr    (o_reg_addr),
      .o_reg_wdata   (o_reg_wdata),
      .i_reg_rdata   (i_reg_rdata),
      .o_rac_crc_err (o_rac_crc_err)
   );

   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int ack_cnt = 0;
   ack_exp_t  ack_q[$];
   bank_exp_t wr_q[$];
   bank_exp_t rd_q[$];
   logic [7:0] bank[128];
   logic [7:0] ref_mem[128];
   logic [7:0] last_d;
   logic [6:0] last_a;

   always @(posedge i_clk) cyc <= cyc + 1;

   // Register bank: read data appears the cycle after the read strobe
   always @(posedge i_clk) begin
      if (o_reg_wr_en) bank[o_reg_addr] <= o_reg_wdata;
      if (o_reg_rd_en) i_reg_rdata <= bank[o_reg_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string nm);
      total++;
      bad++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endtask

   // CRC as the remainder of {1,addr,data}*x^8 divided by x^8+x^2+x+1
   function automatic logic [7:0] ref_crc(input logic [6:0] a, input logic [7:0] d);
      logic [23:0] m;
      m = {1'b1, a, d, 8'h00};
      for (int i = 23; i >= 8; i--)
         if (m[i]) m[i -: 9] = m[i -: 9] ^ 9'h107;
      return m[7:0];
   endfunction

   always @(negedge i_clk) begin
      ack_exp_t  e;
      bank_exp_t b;
      if (!i_rst_n) begin
         last_d = 8'h00;
         last_a = 7'h00;
      end else begin
         if (spi.rac_spi_wack || spi.rac_spi_rack) begin
            chk("both_acks", {31'd0, spi.rac_spi_wack & spi.rac_spi_rack}, 0);
            if (ack_q.size() == 0) fail_now("unexpected_ack");
            else begin
               e = ack_q.pop_front();
               chk("ack_kind", {31'd0, spi.rac_spi_wack}, {31'd0, e.is_wr});
               chk("resp_data", {24'd0, spi.rac_spi_data}, {24'd0, e.data});
               chk("resp_addr", {25'd0, spi.rac_spi_addr}, {25'd0, e.addr});
               chk("crc_err", {31'd0, o_rac_crc_err}, {31'd0, e.err});
               chk("ack_cycle", cyc, e.cyc);
            end
            last_d = spi.rac_spi_data;
            last_a = spi.rac_spi_addr;
            ack_cnt++;
         end else begin
            chk("resp_stable", {17'd0, spi.rac_spi_addr, spi.rac_spi_data},
                {17'd0, last_a, last_d});
            chk("crc_err_no_ack", {31'd0, o_rac_crc_err}, 0);
         end
         if (o_reg_wr_en) begin
            if (wr_q.size() == 0) fail_now("unexpected_wr_en");
            else begin
               b = wr_q.pop_front();
               chk("wr_addr", {25'd0, o_reg_addr}, {25'd0, b.addr});
               chk("wr_data", {24'd0, o_reg_wdata}, {24'd0, b.data});
               chk("wr_cycle", cyc, b.cyc);
            end
         end
         if (o_reg_rd_en) begin
            if (rd_q.size() == 0) fail_now("unexpected_rd_en");
            else begin
               b = rd_q.pop_front();
               chk("rd_addr", {25'd0, o_reg_addr}, {25'd0, b.addr});
               chk("rd_cycle", cyc, b.cyc);
            end
         end
      end
   end

   // Returns one cycle after the ack, i.e. inside GAP
   task automatic wait_ack(input string nm);
      int n0;
      n0 = ack_cnt;
      for (int k = 0; k < 20 && ack_cnt == n0; k++) begin
         @(posedge i_clk);
         #1;
      end
      if (ack_cnt == n0) begin
         fail_now({"timeout_", nm});
         ack_q.delete();
         wr_q.delete();
         rd_q.delete();
      end
   endtask

   task automatic exp_write(input logic [6:0] a, input logic [7:0] d, input bit err, input int c0);
      ack_q.push_back('{1'b1, d, a, err, c0 + (err ? 2 : 3)});
      if (!err) begin
         wr_q.push_back('{a, d, c0 + 2});
         ref_mem[a] = d;
      end
   endtask

   task automatic exp_read(input logic [6:0] a, input int c0);
      rd_q.push_back('{a, 8'h00, c0 + 1});
      ack_q.push_back('{1'b0, ref_mem[a], a, 1'b0, c0 + 3});
   endtask

   task automatic do_write(input logic [6:0] a, input logic [7:0] d, input logic [7:0] flip);
      @(posedge i_clk);
      #1;
      exp_write(a, d, flip != 0, cyc);
      spi.spi_rac_addr   = a;
      spi.spi_rac_wdata  = d;
      spi.spi_rac_wcrc   = ref_crc(a, d) ^ flip;
      spi.spi_rac_wr_req = 1'b1;
      wait_ack("write");
      spi.spi_rac_wr_req = 1'b0;
   endtask

   task automatic do_read(input logic [6:0] a);
      @(posedge i_clk);
      #1;
      exp_read(a, cyc);
      spi.spi_rac_addr   = a;
      spi.spi_rac_rd_req = 1'b1;
      wait_ack("read");
      spi.spi_rac_rd_req = 1'b0;
   endtask

   initial begin
      logic [7:0] v;
      for (int i = 0; i < 128; i++) begin
         v = 8'($urandom);
         bank[i] = v;
         ref_mem[i] = v;
      end
      bank[5] = 8'h3C;
      ref_mem[5] = 8'h3C;
      spi.spi_rac_wr_req = 1'b0;
      spi.spi_rac_rd_req = 1'b0;
      spi.spi_rac_addr   = '0;
      spi.spi_rac_wdata  = '0;
      spi.spi_rac_wcrc   = '0;
      repeat (3) @(posedge i_clk);
      #1;
      chk("rst_outputs", {8'd0, spi.rac_spi_wack, spi.rac_spi_rack, o_reg_wr_en,
          o_reg_rd_en, o_rac_crc_err, spi.rac_spi_data, spi.rac_spi_addr}, 0);
      chk("rst_reg_bus", {17'd0, o_reg_addr, o_reg_wdata}, 0);
      i_rst_n = 1'b1;

      do_write(7'h12, 8'hA5, 8'h00);
      do_write(7'h12, 8'hA5, 8'h01);
      do_read(7'h05);
      do_read(7'h12);

      // Simultaneous requests: write first, read after GAP
      @(posedge i_clk);
      #1;
      begin
         int c0;
         c0 = cyc;
         exp_write(7'h01, 8'h5A, 1'b0, c0);
         exp_read(7'h01, c0 + 5);
      end
      spi.spi_rac_addr   = 7'h01;
      spi.spi_rac_wdata  = 8'h5A;
      spi.spi_rac_wcrc   = ref_crc(7'h01, 8'h5A);
      spi.spi_rac_wr_req = 1'b1;
      spi.spi_rac_rd_req = 1'b1;
      wait_ack("simul_write");
      spi.spi_rac_wr_req = 1'b0;
      wait_ack("simul_read");
      spi.spi_rac_rd_req = 1'b0;

      // Reset during RWAIT aborts; the held read restarts after release
      @(posedge i_clk);
      #1;
      exp_read(7'h33, cyc);
      spi.spi_rac_addr   = 7'h33;
      spi.spi_rac_rd_req = 1'b1;
      repeat (2) begin
         @(posedge i_clk);
         #1;
      end
      i_rst_n = 1'b0;
      void'(ack_q.pop_back());
      #1;
      chk("midrst_outputs", {8'd0, spi.rac_spi_wack, spi.rac_spi_rack, o_reg_wr_en,
          o_reg_rd_en, o_rac_crc_err, spi.rac_spi_data, spi.rac_spi_addr}, 0);
      chk("midrst_reg_bus", {17'd0, o_reg_addr, o_reg_wdata}, 0);
      repeat (2) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      exp_read(7'h33, cyc);
      wait_ack("read_after_reset");
      spi.spi_rac_rd_req = 1'b0;

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 2))
            0:       do_write(7'($urandom), 8'($urandom), 8'h00);
            1:       do_write(7'($urandom), 8'($urandom), 8'(1 << $urandom_range(0, 7)));
            default: do_read(7'($urandom));
         endcase
      end

      repeat (4) @(posedge i_clk);
      chk("queues_drained", ack_q.size() + wr_q.size() + rd_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
